// File: rtl/tis_port_pkg.sv
// Shared definitions for the tis100 15-bit node port: field positions,
// the signed word range and the port handshake state encoding.
package tis_port_pkg;

    // Field positions inside a port word
    localparam int DATA_LSB  = 0;
    localparam int VALID_BIT = 11;
    localparam int ACK_BIT   = 12;

    // Legal value range of a tis100 word
    localparam int TIS_MAX = 999;
    localparam int TIS_MIN = -999;

    // Sender-side four-phase handshake states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } port_state_t;

endpackage

// File: rtl/tis_fifo.sv
// Synchronous show-ahead FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module tis_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write
    // NOTE: the array is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/tis_port_source.sv
// Host-side transmitter for the tis100 node port: saturates and queues
// words, then hands them one at a time to a node over a four-phase
// valid/ack handshake, counting completed transfers.
module tis_port_source
    import tis_port_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 11,
    parameter int PORT_W = 15,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wrEn,
    input  logic signed [DATA_W-1:0]  wrData,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic [PORT_W-1:0]         portOut,
    input  logic [PORT_W-1:0]         portIn,
    output logic                      busy,
    output logic [CNT_W-1:0]          sentCnt
);

    localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'(TIS_MAX);
    localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(TIS_MIN);

    port_state_t              state;
    port_state_t              state_nx;
    logic signed [DATA_W-1:0] sat_data;
    logic [DATA_W-1:0]        head;
    logic [DATA_W-1:0]        data_q;
    logic                     fifo_empty;
    logic                     pop;
    logic                     ack;
    logic                     unused_port_bits;

    // Only the ack bit of the node's return port carries meaning here
    assign ack              = portIn[ACK_BIT];
    assign unused_port_bits = ^{portIn[PORT_W-1:ACK_BIT+1], portIn[ACK_BIT-1:0]};

    // Clamp incoming words to the legal tis100 range before they are queued
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        sat_data = wrData;
        if (wrData > SAT_HI)      sat_data = SAT_HI;
        else if (wrData < SAT_LO) sat_data = SAT_LO;
    end

    tis_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wrEn),
        .push_data (sat_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (full),
        .level     (level)
    );

    // Handshake state register; reset aborts any word in flight
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Handshake next-state: offer, wait for ack, wait for ack release
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nx = REQ;
            REQ:     if (ack)         state_nx = RELEASE;
            RELEASE: if (!ack)        state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // Handshake outputs: pop in IDLE, drive data and valid only while offering
    always_comb begin
        pop     = (state == IDLE) && !fifo_empty;
        busy    = (state != IDLE);
        portOut = '0;
        if (state == REQ) begin
            portOut[VALID_BIT]             = 1'b1;
            portOut[DATA_LSB +: DATA_W]    = data_q;
        end
    end

    // Capture the popped head so it stays stable for the whole offer
    always_ff @(posedge clk) begin
        if (!rst_n)   data_q <= '0;
        else if (pop) data_q <= head;
    end

    // Count transfers at the moment the node acknowledges the offered word
    always_ff @(posedge clk) begin
        if (!rst_n)                     sentCnt <= '0;
        else if ((state == REQ) && ack) sentCnt <= sentCnt + 1'b1;
    end

endmodule
